// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed common-anode 7-segment scanner.
// Ports: clk, rstn (async, active-low); digits, blank_mask, bright in;
//   seg, an_n, cur_digit, frame_pulse out (all registered).
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_W          = 8,
  parameter int DIV            = 50000,
  parameter int BLANK_TICKS    = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int IW = ($clog2(NUM_DIGITS) > 1)
                    ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [3:0]                  bright,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [IW-1:0]               cur_digit,
  output logic                        frame_pulse
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST_PRE = PW'(DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    BT       = 4'(BLANK_TICKS);
  localparam logic [SEG_W-1:0] UNLIT = {SEG_W{SEG_ACTIVE_LOW}};

  logic [PW-1:0] pre_cnt, pre_nx;
  logic [3:0]    phase, phase_nx;
  logic [IW-1:0] idx, idx_nx;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] sh_digits, dig_nx;
  logic [NUM_DIGITS-1:0] sh_mask, mask_nx;
  logic [3:0]            sh_bright, bright_nx;

  logic                  tick, load, on_nx;
  logic [SEG_W-1:0]      seg_nx;
  logic [NUM_DIGITS-1:0] an_nx;

  // Outputs are computed from the next state so the drive and
  // cur_digit change on the same edge as the slot counters.
  always_comb begin
    tick      = (pre_cnt == LAST_PRE);
    load      = tick && (phase == 4'hF) && (idx == LAST_IDX);
    pre_nx    = tick ? '0 : pre_cnt + 1'b1;
    phase_nx  = tick ? phase + 1'b1 : phase;
    idx_nx    = idx;
    if (tick && (phase == 4'hF))
      idx_nx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    dig_nx    = load ? digits     : sh_digits;
    mask_nx   = load ? blank_mask : sh_mask;
    bright_nx = load ? bright     : sh_bright;
    on_nx     = (phase_nx >= BT)
             && (phase_nx <= bright_nx)
             && !mask_nx[idx_nx];
    seg_nx    = UNLIT;
    an_nx     = '1;
    if (on_nx) begin
      seg_nx         = dig_nx[idx_nx] ^ UNLIT;
      an_nx[idx_nx]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt     <= '0;
      phase       <= '0;
      idx         <= '0;
      sh_digits   <= '0;
      sh_mask     <= '1;
      sh_bright   <= '0;
      seg         <= UNLIT;
      an_n        <= '1;
      cur_digit   <= '0;
      frame_pulse <= 1'b0;
    end else begin
      pre_cnt     <= pre_nx;
      phase       <= phase_nx;
      idx         <= idx_nx;
      sh_digits   <= dig_nx;
      sh_mask     <= mask_nx;
      sh_bright   <= bright_nx;
      seg         <= seg_nx;
      an_n        <= an_nx;
      cur_digit   <= idx_nx;
      frame_pulse <= load;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized bench for seg_scan_mux with a
// cycle-count based reference model and literal spot checks.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int SW = 8;
  localparam int DV = 4;
  localparam int BT = 2;
  localparam int FR = ND * 16 * DV;

  logic          clk = 1'b0;
  logic          rstn;
  logic [ND*SW-1:0] digits;
  logic [ND-1:0] blank_mask;
  logic [3:0]    bright;
  logic [SW-1:0] seg;
  logic [ND-1:0] an_n;
  logic [1:0]    cur_digit;
  logic          frame_pulse;

  seg_scan_mux #(
    .NUM_DIGITS(ND), .SEG_W(SW), .DIV(DV),
    .BLANK_TICKS(BT), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .digits(digits),
    .blank_mask(blank_mask), .bright(bright),
    .seg(seg), .an_n(an_n), .cur_digit(cur_digit),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int c = 0;
  bit run_b = 1'b0;
  int lit [ND];

  logic [ND*SW-1:0] m_dig;
  logic [ND-1:0]    m_mask;
  logic [3:0]       m_bright;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dig    = '0;
    m_mask   = '1;
    m_bright = '0;
    for (int k = 0; k < ND; k++) lit[k] = 0;
  endtask

  task automatic rand_drive();
    if ($urandom_range(15) == 0 || c % FR == FR - 1) begin
      digits     = $urandom;
      blank_mask = 4'($urandom);
      bright     = 4'($urandom_range(15));
    end
  endtask

  task automatic frame_lits(int f);
    int want [ND];
    bit  do_chk;
    do_chk = 1'b1;
    for (int k = 0; k < ND; k++) want[k] = 0;
    if (!run_b) begin
      case (f)
        0: ;
        1: for (int k = 0; k < ND; k++) want[k] = 56;
        2: for (int k = 0; k < ND; k++) want[k] = 16;
        3: ;
        4: begin
          for (int k = 0; k < ND; k++) want[k] = 56;
          want[2] = 0;
        end
        default: do_chk = 1'b0;
      endcase
    end else if (f != 0) begin
      do_chk = 1'b0;
    end
    if (do_chk)
      for (int k = 0; k < ND; k++)
        chk($sformatf("lit_f%0d_d%0d", f, k),
            32'(lit[k]), 32'(want[k]));
    for (int k = 0; k < ND; k++) lit[k] = 0;
  endtask

  task automatic step();
    int ph, id;
    bit on;
    logic [ND-1:0] ea;
    logic [SW-1:0] es;
    logic ef;
    ph = (c / DV) % 16;
    id = (c / (16 * DV)) % ND;
    on = (ph >= BT) && (ph <= int'(m_bright))
      && !m_mask[id];
    ea = on ? ~(4'b0001 << id) : 4'hF;
    es = on ? ~m_dig[id*SW +: SW] : 8'hFF;
    ef = (c > 0) && (c % FR == 0);
    chk("an_n", 32'(an_n), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("cur_digit", 32'(cur_digit), 32'(id));
    chk("frame_pulse", 32'(frame_pulse), 32'(ef));
    chk("excl", 32'($countones(~an_n) <= 1), 32'd1);
    if (!run_b) begin
      if (c == 256) chk("lit_fp256", 32'(frame_pulse), 32'd1);
      if (c == 263) chk("lit_an263", 32'(an_n), 32'hF);
      if (c == 264) begin
        chk("lit_an264", 32'(an_n), 32'hE);
        chk("lit_seg264", 32'(seg), 32'hB0);
      end
      if (c == 330) begin
        chk("lit_an330", 32'(an_n), 32'hD);
        chk("lit_seg330", 32'(seg), 32'hA4);
      end
      if (c == 520) begin
        chk("lit_an520", 32'(an_n), 32'hE);
        chk("lit_seg520", 32'(seg), 32'h99);
      end
    end
    for (int k = 0; k < ND; k++)
      if (an_n[k] == 1'b0) lit[k]++;
    if (c % FR == FR - 1) frame_lits(c / FR);
    if (!run_b) begin
      if (c == 300) begin
        digits = 32'h065B4F66;
        bright = 4'd5;
      end
      if (c == 600) bright = 4'd1;
      if (c == 800) begin
        blank_mask = 4'b0100;
        bright     = 4'd15;
        digits     = $urandom;
      end
      if (c >= 1024) rand_drive();
    end else begin
      rand_drive();
    end
    if (c % FR == FR - 1) begin
      m_dig    = digits;
      m_mask   = blank_mask;
      m_bright = bright;
    end
    @(negedge clk);
    c++;
  endtask

  initial begin
    rstn       = 1'b0;
    digits     = 32'h3F065B4F;
    blank_mask = 4'b0000;
    bright     = 4'd15;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    c = 0;
    repeat (2704) step();
    #2 rstn = 1'b0;
    #1;
    chk("rst_an_n", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_cur", 32'(cur_digit), 32'd0);
    chk("rst_fp", 32'(frame_pulse), 32'd0);
    repeat (3) @(negedge clk);
    rstn  = 1'b1;
    run_b = 1'b1;
    c = 0;
    model_reset();
    repeat (3 * FR) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
